// File: rtl/inst_fetch_queue_if.sv
// Fetch-bus, redirect and decode-side signals of the instruction fetch queue.
// master = fetch queue, slave = memory bus + decode environment.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 3
);
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok;
  logic              inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [DATA_W-1:0] out_inst;
  logic              out_ready;
  logic [CNT_W-1:0]  count;

  modport master (
    output inst_req, inst_addr, out_valid, out_pc, out_inst, count,
    input  inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  inst_req, inst_addr, out_valid, out_pc, out_inst, count,
    output inst_addr_ok, inst_data_ok, inst_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Sequential fetch front end: credit-limited requests on a split addr_ok/data_ok bus,
// in-flight PC tracking, {pc,inst} FIFO to decode, and redirect flush with response discard.
module inst_fetch_queue #(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hbfc00000
) (
  input  logic clk,
  input  logic resetn,
  inst_fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  localparam int OW = $clog2(MAX_OUTST+1);
  localparam int PW = $clog2(DEPTH);
  localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  logic [ADDR_W-1:0]                 fetch_pc_q, fetch_pc_d;
  logic [OW-1:0]                     outst_q, outst_d, disc_q, disc_d;
  logic [CW-1:0]                     count_q, count_d;
  logic [PW-1:0]                     wr_q, rd_q;
  logic [DEPTH-1:0][ADDR_W-1:0]      fpc_q;
  logic [DEPTH-1:0][DATA_W-1:0]      finst_q;
  logic [MAX_OUTST-1:0][ADDR_W-1:0]  ipc_q;
  logic [QW-1:0]                     iwr_q, ird_q;
  logic                              accept, rsp, push, pop, redir;

  function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUTST-1)) ? '0 : p + QW'(1);
  endfunction

  // Credits count both buffered entries and in-flight requests, so a push never finds the FIFO full.
  assign bus.inst_req  = resetn && !bus.redirect_valid &&
                         (int'(count_q) + int'(outst_q) < DEPTH) && (int'(outst_q) < MAX_OUTST);
  assign bus.inst_addr = fetch_pc_q;
  assign bus.out_valid = (count_q != '0);
  assign bus.out_pc    = fpc_q[rd_q];
  assign bus.out_inst  = finst_q[rd_q];
  assign bus.count     = count_q;

  assign redir  = bus.redirect_valid;
  assign accept = bus.inst_req & bus.inst_addr_ok;
  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp    = bus.inst_data_ok & (outst_q != '0);
  assign push   = rsp & (disc_q == '0) & !redir;
  assign pop    = bus.out_valid & bus.out_ready & !redir;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redir)       fetch_pc_d = bus.redirect_pc;
    else if (accept) fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    outst_d = outst_q + OW'(accept) - OW'(rsp);
    if (redir) disc_d = outst_q + OW'(accept) - OW'(rsp);
    else       disc_d = disc_q - OW'(rsp && (disc_q != '0));
    if (redir) count_d = '0;
    else       count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      disc_q     <= '0;
      count_q    <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      fpc_q      <= '0;
      finst_q    <= '0;
      ipc_q      <= '0;
      iwr_q      <= '0;
      ird_q      <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      count_q    <= count_d;
      if (accept) begin
        ipc_q[iwr_q] <= fetch_pc_q;
        iwr_q        <= qinc(iwr_q);
      end
      if (rsp) ird_q <= qinc(ird_q);
      if (redir) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) begin
          fpc_q[wr_q]   <= ipc_q[ird_q];
          finst_q[wr_q] <= bus.inst_rdata;
          wr_q          <= wr_q + PW'(1);
        end
        if (pop) rd_q <= rd_q + PW'(1);
      end
    end
  end

  a_no_orphan_rsp: assert property (@(posedge clk) disable iff (!resetn)
    bus.inst_data_ok |-> (outst_q != '0));
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Random-stimulus bench for inst_fetch_queue against a queue-based model of the fetch stream.
module tb_inst_fetch_queue;
  localparam int          DEPTH     = 4;
  localparam int          MAX_OUTST = 2;
  localparam logic [31:0] RST_PC    = 32'hbfc00000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) bus ();
  inst_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST),
                     .RESET_PC(RST_PC)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;

  // Model: PCs waiting in the decode FIFO, and in-flight PCs with a discard flag.
  logic [31:0] m_fifo[$];
  logic [31:0] m_ipc[$];
  bit          m_idrop[$];
  logic [31:0] m_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h13579bdf;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.inst_addr_ok   = 1'b0;
    bus.inst_data_ok   = 1'b0;
    bus.inst_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.out_ready      = 1'b0;
  endtask

  // Entered at a negedge; asserts reset, checks outputs drop at once, holds two cycles, releases.
  task automatic do_reset();
    resetn = 1'b0;
    drive_idle();
    #1;
    chk("rst_req",   64'(bus.inst_req),  64'd0);
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_count", 64'(bus.count),     64'd0);
    chk("rst_pc",    64'(bus.out_pc),    64'd0);
    chk("rst_inst",  64'(bus.out_inst),  64'd0);
    m_fifo.delete(); m_ipc.delete(); m_idrop.delete();
    m_pc = RST_PC;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // One cycle: check state outputs, drive inputs, check request, advance model, move to next negedge.
  task automatic step(input int p_aok, input int p_dok, input int p_rdy, input int p_rv,
                      input bit rnd_pc, input logic [31:0] rpc);
    bit rv, aok, dok, rdy, req_exp, acc, pop, keep;
    logic [31:0] hpc;
    chk("out_valid", 64'(bus.out_valid), 64'(m_fifo.size() != 0));
    chk("count", 64'(bus.count), 64'(m_fifo.size()));
    if (m_fifo.size() != 0) begin
      chk("out_pc",   64'(bus.out_pc),   64'(m_fifo[0]));
      chk("out_inst", 64'(bus.out_inst), 64'(inst_of(m_fifo[0])));
    end
    rv  = ($urandom_range(99) < p_rv);
    aok = ($urandom_range(99) < p_aok);
    dok = (m_ipc.size() != 0) && ($urandom_range(99) < p_dok);
    rdy = ($urandom_range(99) < p_rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rnd_pc ? {$urandom(), 2'b00} >> 0 : rpc;
    if (rnd_pc) bus.redirect_pc[1:0] = 2'b00;
    bus.inst_addr_ok   = aok;
    bus.inst_data_ok   = dok;
    bus.inst_rdata     = dok ? inst_of(m_ipc[0]) : $urandom();
    bus.out_ready      = rdy;
    req_exp = !rv && (m_fifo.size() + m_ipc.size() < DEPTH) && (m_ipc.size() < MAX_OUTST);
    #1;
    chk("inst_req", 64'(bus.inst_req), 64'(req_exp));
    if (req_exp) chk("inst_addr", 64'(bus.inst_addr), 64'(m_pc));
    acc = req_exp && aok;
    pop = !rv && rdy && (m_fifo.size() != 0);
    keep = 1'b0;
    hpc  = '0;
    if (dok) begin
      hpc  = m_ipc.pop_front();
      keep = !m_idrop.pop_front() && !rv;
    end
    if (pop)  void'(m_fifo.pop_front());
    if (keep) m_fifo.push_back(hpc);
    if (acc) begin
      m_ipc.push_back(m_pc);
      m_idrop.push_back(1'b0);
      m_pc = m_pc + 32'd4;
    end
    if (rv) begin
      m_fifo.delete();
      foreach (m_idrop[i]) m_idrop[i] = 1'b1;
      m_pc = bus.redirect_pc;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    drive_idle();
    #1;
    chk("init_req",   64'(bus.inst_req),  64'd0);
    chk("init_valid", 64'(bus.out_valid), 64'd0);
    @(negedge clk);
    do_reset();
    // Free-flowing bus and decode.
    repeat (20) step(100, 100, 100, 0, 1'b0, '0);
    // Decode stalled: FIFO fills, requests stop; then drain.
    repeat (12) step(100, 100, 0, 0, 1'b0, '0);
    chk("full_count", 64'(bus.count), 64'(DEPTH));
    repeat (12) step(100, 100, 100, 0, 1'b0, '0);
    // Build up two outstanding requests, then redirect.
    repeat (4) step(100, 0, 100, 0, 1'b0, '0);
    chk("outst_full", 64'(m_ipc.size()), 64'(MAX_OUTST));
    step(100, 0, 100, 100, 1'b0, 32'hbfc00100);
    repeat (10) step(100, 100, 100, 0, 1'b0, '0);
    // Withheld responses, then resume.
    repeat (6) step(100, 0, 100, 0, 1'b0, '0);
    repeat (10) step(100, 100, 100, 0, 1'b0, '0);
    // Random mixes, including redirects coinciding with responses and accepts.
    repeat (1500) step(70, 60, 60, 5, 1'b0, 32'hbfc00200);
    repeat (1500) step($urandom_range(100), $urandom_range(100), $urandom_range(100), 8, 1'b1, '0);
    // Reset mid-run with a loaded FIFO and requests in flight.
    repeat (6) step(100, 50, 0, 0, 1'b0, '0);
    do_reset();
    repeat (300) step(80, 70, 70, 3, 1'b1, '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end
endmodule
